proc_scycle_tinyrv1: RTL and testbench

Single-cycle TinyRV1 processor core: fetches, decodes, executes and retires one instruction per clock. It connects to an external instruction memory port and data memory port, both combinational-read. It exposes three input and three output CSR-mapped ports plus a per-cycle retirement trace. It is the top of the processor datapath and is paired in simulation with the team's test memory model.

---
 rtl/proc_scycle_tinyrv1_if.sv | 35 +++
 rtl/proc_scycle_tinyrv1.sv | 187 ++++++++++++++++++
 tb/tb_proc_scycle_tinyrv1.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_scycle_tinyrv1_if.sv
// Instruction and data memory ports of the single-cycle TinyRV1 core.
// There is no ready: a request is live whenever its *_val is high, memory answers
// combinationally in the same cycle, and a write (type=1) commits on the next rising edge.
interface proc_scycle_tinyrv1_if;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;

  modport master (
    output imemreq_val,
    output imemreq_addr,
    input  imemresp_data,
    output dmemreq_val,
    output dmemreq_type,
    output dmemreq_addr,
    output dmemreq_wdata,
    input  dmemresp_rdata
  );

  modport slave (
    input  imemreq_val,
    input  imemreq_addr,
    output imemresp_data,
    input  dmemreq_val,
    input  dmemreq_type,
    input  dmemreq_addr,
    input  dmemreq_wdata,
    output dmemresp_rdata
  );
endinterface

// File: rtl/proc_scycle_tinyrv1.sv
// Single-cycle TinyRV1 core: fetch, decode, execute, memory and write-back all
// happen combinationally within one clock; PC, GPRs and out CSRs commit at the edge.
module proc_scycle_tinyrv1 (
  input  logic                         clk,
  input  logic                         rst,
  proc_scycle_tinyrv1_if.master        mem,
  input  logic [31:0]                  in0,
  input  logic [31:0]                  in1,
  input  logic [31:0]                  in2,
  output logic [31:0]                  out0,
  output logic [31:0]                  out1,
  output logic [31:0]                  out2,
  output logic                         trace_val,
  output logic [31:0]                  trace_addr,
  output logic [31:0]                  trace_data
);

  localparam logic [31:0] RESET_PC = 32'h0000_0200;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_MUL, OP_ADDI, OP_LW, OP_SW,
    OP_JAL, OP_JR, OP_BNE, OP_CSRR, OP_CSRW
  } op_e;

  logic [31:0] pc;
  logic [31:0] rf [0:31];

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] csr_num;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] mul_res;
  op_e         op;

  logic [31:0] next_pc;
  logic        wb_en;
  logic [31:0] wb_data;
  logic        mem_val;
  logic        mem_type;
  logic [31:0] mem_addr;
  logic        csr_we;

  assign inst    = mem.imemresp_data;
  assign opcode  = inst[6:0];
  assign rd      = inst[11:7];
  assign funct3  = inst[14:12];
  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign funct7  = inst[31:25];
  assign csr_num = inst[31:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // x0 is never written, but the read guard keeps it at zero regardless of storage.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign mul_res = rs1_val * rs2_val;

  // Decode: anything not matching exactly one supported form falls back to a nop.
  always_comb begin
    op = OP_NOP;
    case (opcode)
      OPC_OP: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) op = OP_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0000001) op = OP_MUL;
      end
      OPC_OP_IMM: if (funct3 == 3'b000) op = OP_ADDI;
      OPC_LOAD:   if (funct3 == 3'b010) op = OP_LW;
      OPC_STORE:  if (funct3 == 3'b010) op = OP_SW;
      OPC_JAL:    op = OP_JAL;
      OPC_JALR: begin
        if (funct3 == 3'b000 && rd == 5'd0 && csr_num == 12'd0) op = OP_JR;
      end
      OPC_BRANCH: if (funct3 == 3'b001) op = OP_BNE;
      OPC_SYSTEM: begin
        if (funct3 == 3'b010 && rs1 == 5'd0 &&
            (csr_num == 12'hFC2 || csr_num == 12'hFC3 || csr_num == 12'hFC4))
          op = OP_CSRR;
        else if (funct3 == 3'b001 && rd == 5'd0 &&
                 (csr_num == 12'h7C2 || csr_num == 12'h7C3 || csr_num == 12'h7C4))
          op = OP_CSRW;
      end
      default: op = OP_NOP;
    endcase
  end

  // Execute, memory access and write-back selection.
  always_comb begin
    next_pc  = pc + 32'd4;
    wb_en    = 1'b0;
    wb_data  = 32'd0;
    mem_val  = 1'b0;
    mem_type = 1'b0;
    mem_addr = rs1_val + imm_i;
    csr_we   = 1'b0;
    case (op)
      OP_ADD: begin
        wb_en   = 1'b1;
        wb_data = rs1_val + rs2_val;
      end
      OP_MUL: begin
        wb_en   = 1'b1;
        wb_data = mul_res;
      end
      OP_ADDI: begin
        wb_en   = 1'b1;
        wb_data = rs1_val + imm_i;
      end
      OP_LW: begin
        mem_val = 1'b1;
        wb_en   = 1'b1;
        wb_data = mem.dmemresp_rdata;
      end
      OP_SW: begin
        mem_val  = 1'b1;
        mem_type = 1'b1;
        mem_addr = rs1_val + imm_s;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OP_JR:  next_pc = rs1_val;
      OP_BNE: if (rs1_val != rs2_val) next_pc = pc + imm_b;
      OP_CSRR: begin
        wb_en = 1'b1;
        case (csr_num)
          12'hFC2: wb_data = in0;
          12'hFC3: wb_data = in1;
          default: wb_data = in2;
        endcase
      end
      OP_CSRW: csr_we = 1'b1;
      default: ;
    endcase
  end

  // rst is active-low: while it is low nothing retires and no memory request is issued.
  assign mem.imemreq_val   = rst;
  assign mem.imemreq_addr  = pc;
  assign mem.dmemreq_val   = rst & mem_val;
  assign mem.dmemreq_type  = mem_type;
  assign mem.dmemreq_addr  = mem_addr;
  assign mem.dmemreq_wdata = rs2_val;

  assign trace_val  = rst;
  assign trace_addr = pc;
  assign trace_data = (rst && wb_en && rd != 5'd0) ? wb_data : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc   <= RESET_PC;
      out0 <= 32'd0;
      out1 <= 32'd0;
      out2 <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (wb_en && rd != 5'd0) rf[rd] <= wb_data;
      if (csr_we) begin
        case (csr_num)
          12'h7C2: out0 <= rs1_val;
          12'h7C3: out1 <= rs1_val;
          default: out2 <= rs1_val;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_proc_scycle_tinyrv1.sv
// Directed bench for proc_scycle_tinyrv1: a small program with hand-computed
// per-cycle trace values, memory request checks and reset behaviour.
module tb_proc_scycle_tinyrv1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] in0, in1, in2;
  logic [31:0] out0, out1, out2;
  logic        trace_val;
  logic [31:0] trace_addr, trace_data;

  proc_scycle_tinyrv1_if mem_if ();

  proc_scycle_tinyrv1 dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mem_if),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .trace_val  (trace_val),
    .trace_addr (trace_addr),
    .trace_data (trace_data)
  );

  // ---------------- test memory ----------------
  logic [31:0] mem [0:1023];

  always_comb mem_if.imemresp_data  = mem[mem_if.imemreq_addr[11:2]];
  always_comb mem_if.dmemresp_rdata = mem[mem_if.dmemreq_addr[11:2]];

  always @(posedge clk) begin
    if (mem_if.dmemreq_val && mem_if.dmemreq_type)
      mem[mem_if.dmemreq_addr[11:2]] <= mem_if.dmemreq_wdata;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle(input logic r);
    @(posedge clk);
    #3 rst = r;
    #5;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[11:2]] = word;
  endtask

  task automatic expect_trace(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // ---------------- assembler helpers ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_bne(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] e;
    logic [31:0] ea, ed;

    rst = 1'b0;
    in0 = 32'h1111_1111;
    in1 = 32'h2222_2222;
    in2 = 32'h3333_3333;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

    put(32'h100, 32'hCAFE_0123);
    put(32'h108, 32'h0BAD_F00D);
    put(32'h900, 32'h1234_5678);

    put(32'h200, addi(5'd1, 5'd0, 32'h100));                     expect_trace(32'h200, 32'h0000_0100);
    put(32'h204, lw(5'd2, 5'd1, 32'd0));                         expect_trace(32'h204, 32'hCAFE_0123);
    put(32'h208, lw(5'd3, 5'd1, 32'd8));                         expect_trace(32'h208, 32'h0BAD_F00D);
    put(32'h20C, addi(5'd1, 5'd1, 32'd8));                       expect_trace(32'h20C, 32'h0000_0108);
    put(32'h210, lw(5'd4, 5'd1, -32'sd8));                       expect_trace(32'h210, 32'hCAFE_0123);
    put(32'h214, addi(5'd1, 5'd0, 32'h101));                     expect_trace(32'h214, 32'h0000_0101);
    put(32'h218, lw(5'd5, 5'd1, 32'd2047));                      expect_trace(32'h218, 32'h1234_5678);
    put(32'h21C, addi(5'd1, 5'd0, 32'h102));                     expect_trace(32'h21C, 32'h0000_0102);
    put(32'h220, lw(5'd6, 5'd1, 32'd0));                         expect_trace(32'h220, 32'hCAFE_0123);
    put(32'h224, lw(5'd0, 5'd1, 32'd0));                         expect_trace(32'h224, 32'h0000_0000);
    put(32'h228, enc_r(7'b0000000, 5'd0, 5'd2, 5'd7));           expect_trace(32'h228, 32'hCAFE_0123);
    put(32'h22C, enc_r(7'b0000001, 5'd1, 5'd3, 5'd8));           expect_trace(32'h22C, 32'hC54B_ED1A);
    put(32'h230, enc_sw(32'h10, 5'd8, 5'd0));                    expect_trace(32'h230, 32'h0000_0000);
    put(32'h234, lw(5'd9, 5'd0, 32'h10));                        expect_trace(32'h234, 32'hC54B_ED1A);
    put(32'h238, enc_i(32'hFC2, 5'd0, 3'b010, 5'd10, 7'b1110011)); expect_trace(32'h238, 32'h1111_1111);
    put(32'h23C, enc_i(32'hFC4, 5'd0, 3'b010, 5'd11, 7'b1110011)); expect_trace(32'h23C, 32'h3333_3333);
    put(32'h240, enc_i(32'h7C3, 5'd9, 3'b001, 5'd0, 7'b1110011));  expect_trace(32'h240, 32'h0000_0000);
    put(32'h244, enc_bne(32'd8, 5'd9, 5'd0));                    expect_trace(32'h244, 32'h0000_0000);
    put(32'h248, addi(5'd12, 5'd0, 32'd1));
    put(32'h24C, enc_jal(32'd8, 5'd13));                         expect_trace(32'h24C, 32'h0000_0250);
    put(32'h250, addi(5'd12, 5'd0, 32'd2));
    put(32'h254, addi(5'd14, 5'd0, 32'h260));                    expect_trace(32'h254, 32'h0000_0260);
    put(32'h258, enc_i(32'd0, 5'd14, 3'b000, 5'd0, 7'b1100111)); expect_trace(32'h258, 32'h0000_0000);
    put(32'h25C, addi(5'd12, 5'd0, 32'd3));
    put(32'h260, enc_bne(32'd8, 5'd9, 5'd9));                    expect_trace(32'h260, 32'h0000_0000);
    put(32'h264, 32'hFFFF_FFFF);                                 expect_trace(32'h264, 32'h0000_0000);
    put(32'h268, enc_i(32'hFC7, 5'd0, 3'b010, 5'd15, 7'b1110011)); expect_trace(32'h268, 32'h0000_0000);
    put(32'h26C, addi(5'd16, 5'd0, 32'hFFFF_FFFF));              expect_trace(32'h26C, 32'hFFFF_FFFF);
    put(32'h270, enc_r(7'b0000000, 5'd16, 5'd16, 5'd17));        expect_trace(32'h270, 32'hFFFF_FFFE);
    put(32'h274, addi(5'd0, 5'd0, 32'd5));                       expect_trace(32'h274, 32'h0000_0000);
    put(32'h278, enc_sw(32'h20, 5'd16, 5'd0));

    // two cycles held in reset
    for (int c = 0; c < 2; c++) begin
      next_cycle(1'b0);
      check("rst_trace_val", {31'd0, trace_val}, 32'd0);
      check("rst_imem_val", {31'd0, mem_if.imemreq_val}, 32'd0);
      check("rst_dmem_val", {31'd0, mem_if.dmemreq_val}, 32'd0);
      check("rst_out0", out0, 32'd0);
      check("rst_out1", out1, 32'd0);
      check("rst_out2", out2, 32'd0);
    end

    // program run, one retirement per cycle
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ea = e[63:32];
      ed = e[31:0];
      next_cycle(1'b1);
      check("trace_val", {31'd0, trace_val}, 32'd1);
      check($sformatf("trace_addr@%0h", ea), trace_addr, ea);
      check($sformatf("imem_addr@%0h", ea), mem_if.imemreq_addr, ea);
      check($sformatf("trace_data@%0h", ea), trace_data, ed);
      case (ea)
        32'h204, 32'h208, 32'h210, 32'h218, 32'h220: begin
          check($sformatf("dmem_val@%0h", ea), {31'd0, mem_if.dmemreq_val}, 32'd1);
          check($sformatf("dmem_type@%0h", ea), {31'd0, mem_if.dmemreq_type}, 32'd0);
        end
        default: ;
      endcase
      case (ea)
        32'h204: check("dmem_addr_base", mem_if.dmemreq_addr, 32'h100);
        32'h208: check("dmem_addr_pos", mem_if.dmemreq_addr, 32'h108);
        32'h210: check("dmem_addr_neg", mem_if.dmemreq_addr, 32'h100);
        32'h218: check("dmem_addr_max", mem_if.dmemreq_addr, 32'h900);
        32'h220: check("dmem_addr_unaligned", mem_if.dmemreq_addr, 32'h102);
        32'h230: begin
          check("sw_val", {31'd0, mem_if.dmemreq_val}, 32'd1);
          check("sw_type", {31'd0, mem_if.dmemreq_type}, 32'd1);
          check("sw_addr", mem_if.dmemreq_addr, 32'h10);
          check("sw_wdata", mem_if.dmemreq_wdata, 32'hC54B_ED1A);
        end
        32'h238: check("csrr_dmem_val", {31'd0, mem_if.dmemreq_val}, 32'd0);
        32'h244: begin
          check("out0_after_csrw", out0, 32'd0);
          check("out1_after_csrw", out1, 32'hC54B_ED1A);
          check("out2_after_csrw", out2, 32'd0);
        end
        default: ;
      endcase
    end

    // reset asserted while the sw at 0x278 is in flight
    next_cycle(1'b0);
    check("midrst_trace_val", {31'd0, trace_val}, 32'd0);
    check("midrst_dmem_val", {31'd0, mem_if.dmemreq_val}, 32'd0);
    next_cycle(1'b0);
    check("midrst_out1", out1, 32'd0);
    check("midrst_sw_dropped", mem[32'h20 >> 2], 32'd0);
    next_cycle(1'b1);
    check("restart_trace_val", {31'd0, trace_val}, 32'd1);
    check("restart_trace_addr", trace_addr, 32'h200);
    check("restart_trace_data", trace_data, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
